// File: rtl/line_arbiter_n.sv
// Line arbiter: serialises per-port line read/write requests onto a single downstream port.
// One transaction in flight at a time; round-robin or fixed-priority port selection.
module line_arbiter_n #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned PRIO_MODE = 0,
  localparam int unsigned IdxW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        up_read,
  input  logic [NUM_PORTS-1:0]        up_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] up_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] up_wdata,
  output logic [NUM_PORTS-1:0]        up_resp,
  output logic [LINE_W-1:0]           up_rdata,
  output logic                        dn_read,
  output logic                        dn_write,
  output logic [ADDR_W-1:0]           dn_addr,
  output logic [LINE_W-1:0]           dn_wdata,
  input  logic                        dn_resp,
  input  logic [LINE_W-1:0]           dn_rdata,
  output logic                        busy,
  output logic [IdxW-1:0]             grant_id
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e               state_q;
  logic [IdxW-1:0]      rr_ptr_q;
  logic [NUM_PORTS-1:0] req;
  logic [IdxW-1:0]      cand;
  logic [IdxW-1:0]      sel_idx;
  logic                 sel_valid;
  logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
  logic [LINE_W-1:0]    wdata_arr [NUM_PORTS];

  assign req  = up_read | up_write;
  assign busy = (state_q != StIdle);

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_arr[i]  = up_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = up_wdata[i*LINE_W +: LINE_W];
    end
  end

  // Both searches run from the lowest-preference candidate upward, so the last hit is the winner.
  always_comb begin
    cand      = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    if (PRIO_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        cand = IdxW'(i);
        if (req[cand]) begin
          sel_idx   = cand;
          sel_valid = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        cand = IdxW'((int'(rr_ptr_q) + k) % int'(NUM_PORTS));
        if (req[cand]) begin
          sel_idx   = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= IdxW'(NUM_PORTS - 1);
      grant_id <= '0;
      dn_read  <= 1'b0;
      dn_write <= 1'b0;
      dn_addr  <= '0;
      dn_wdata <= '0;
      up_resp  <= '0;
      up_rdata <= '0;
    end else begin
      up_resp <= '0;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            grant_id <= sel_idx;
            rr_ptr_q <= sel_idx;
            // Write wins when a port raises both read and write.
            dn_write <= up_write[sel_idx];
            dn_read  <= ~up_write[sel_idx];
            dn_addr  <= addr_arr[sel_idx];
            dn_wdata <= wdata_arr[sel_idx];
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (dn_resp) begin
            if (dn_read) up_rdata <= dn_rdata;
            up_resp[grant_id] <= 1'b1;
            dn_read  <= 1'b0;
            dn_write <= 1'b0;
            state_q  <= StRelease;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule
